// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel position, visible flag, syncs and line/frame strobes.
// Every output is registered and always describes the position held in o_hpos/o_vpos.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_visible,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_start,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {HOLD, RUN} state_t;

  state_t      state;
  logic        h_wrap;
  logic [9:0]  next_h;
  logic [9:0]  next_v;
  logic [10:0] next_h_ext;
  logic [10:0] next_v_ext;
  logic        hsync_on;
  logic        vsync_on;
  logic        visible_next;

  // Flags are decoded from the position about to be loaded, so they stay aligned with it.
  always_comb begin
    h_wrap = (o_hpos == H_LAST);
    next_h = h_wrap ? 10'd0 : o_hpos + 10'd1;
    next_v = o_vpos;
    if (h_wrap) begin
      next_v = (o_vpos == V_LAST) ? 10'd0 : o_vpos + 10'd1;
    end
    next_h_ext   = {1'b0, next_h};
    next_v_ext   = {1'b0, next_v};
    hsync_on     = (next_h_ext >= H_SYNC_BEG) && (next_h_ext < H_SYNC_END);
    vsync_on     = (next_v_ext >= V_SYNC_BEG) && (next_v_ext < V_SYNC_END);
    visible_next = (next_h_ext < H_VIS_END) && (next_v_ext < V_VIS_END);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= HOLD;
      o_hpos        <= 10'd0;
      o_vpos        <= 10'd0;
      o_visible     <= 1'b0;
      o_hsync       <= ~SYNC_ACTIVE;
      o_vsync       <= ~SYNC_ACTIVE;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (!i_ce) begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      case (state)
        // First enabled edge presents (0,0) without advancing so it is never skipped.
        HOLD: begin
          state         <= RUN;
          o_hpos        <= 10'd0;
          o_vpos        <= 10'd0;
          o_visible     <= 1'b1;
          o_hsync       <= ~SYNC_ACTIVE;
          o_vsync       <= ~SYNC_ACTIVE;
          o_line_start  <= 1'b1;
          o_frame_start <= 1'b1;
        end
        RUN: begin
          o_hpos        <= next_h;
          o_vpos        <= next_v;
          o_visible     <= visible_next;
          o_hsync       <= hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
          o_vsync       <= vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
          o_line_start  <= (next_h == 10'd0);
          o_frame_start <= (next_h == 10'd0) && (next_v == 10'd0);
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: the default 640x480 build plus two tiny rasters
// (active-low and active-high sync) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  always #5 clk = ~clk;

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos, i_hpos, i_vpos;
  logic d_visible, d_hsync, d_vsync, d_ls, d_fs;
  logic s_visible, s_hsync, s_vsync, s_ls, s_fs;
  logic i_visible, i_hsync, i_vsync, i_ls, i_fs;

  int total = 0;
  int bad = 0;
  int cyc = -1;
  int edges = 0;
  int err_d = 0;
  int err_s = 0;
  int err_i = 0;

  vga_timing_gen dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .o_hpos(d_hpos), .o_vpos(d_vpos), .o_visible(d_visible),
    .o_hsync(d_hsync), .o_vsync(d_vsync),
    .o_line_start(d_ls), .o_frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) dut_small (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .o_hpos(s_hpos), .o_vpos(s_vpos), .o_visible(s_visible),
    .o_hsync(s_hsync), .o_vsync(s_vsync),
    .o_line_start(s_ls), .o_frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE(1'b1)
  ) dut_inv (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .o_hpos(i_hpos), .o_vpos(i_vpos), .o_visible(i_visible),
    .o_hsync(i_hsync), .o_vsync(i_vsync),
    .o_line_start(i_ls), .o_frame_start(i_fs)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected outputs straight from the raster definition, indexed by enabled-cycle count c.
  function automatic logic [24:0] expectVec(input int c, input int ht, input int vt,
                                            input int hv, input int hss, input int hse,
                                            input int vv, input int vss, input int vse,
                                            input bit act, input bit strobe);
    int h, v;
    logic vis, hsy, vsy, ls, fs;
    if (c < 0) return {10'd0, 10'd0, 1'b0, ~act, ~act, 1'b0, 1'b0};
    h   = c % ht;
    v   = (c / ht) % vt;
    vis = (h < hv) && (v < vv);
    hsy = (h >= hss && h < hse) ? act : ~act;
    vsy = (v >= vss && v < vse) ? act : ~act;
    ls  = strobe && (h == 0);
    fs  = ls && (v == 0);
    return {10'(h), 10'(v), vis, hsy, vsy, ls, fs};
  endfunction

  task automatic tick();
    bit en;
    logic [24:0] exp_d, exp_s, exp_i;
    en = ce && !rst;
    @(posedge clk);
    #1;
    edges++;
    if (rst) cyc = -1;
    else if (en) cyc++;
    exp_d = expectVec(cyc, 800, 525, 640, 656, 752, 480, 490, 492, 1'b0, en);
    exp_s = expectVec(cyc, 15, 10, 8, 10, 13, 6, 7, 9, 1'b0, en);
    exp_i = expectVec(cyc, 15, 10, 8, 10, 13, 6, 7, 9, 1'b1, en);
    if ({d_hpos, d_vpos, d_visible, d_hsync, d_vsync, d_ls, d_fs} != exp_d) err_d++;
    if ({s_hpos, s_vpos, s_visible, s_hsync, s_vsync, s_ls, s_fs} != exp_s) err_s++;
    if ({i_hpos, i_vpos, i_visible, i_hsync, i_vsync, i_ls, i_fs} != exp_i) err_i++;
  endtask

  task automatic applyStimulus(input logic r, input logic c, input int n);
    rst = r;
    ce  = c;
    repeat (n) tick();
  endtask

  initial begin
    int vis_count, hs_low, hs_first, hs_last;
    int last_fs, fs_gap, sv_low, iv_high;

    rst = 1'b1;
    ce  = 1'b1;
    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("rst_hpos", int'(d_hpos), 0);
    checkOutput("rst_vpos", int'(d_vpos), 0);
    checkOutput("rst_visible", int'(d_visible), 0);
    checkOutput("rst_hsync", int'(d_hsync), 1);
    checkOutput("rst_vsync", int'(d_vsync), 1);
    checkOutput("rst_line_start", int'(d_ls), 0);
    checkOutput("rst_frame_start", int'(d_fs), 0);
    checkOutput("rst_inv_hsync", int'(i_hsync), 0);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("first_hpos", int'(d_hpos), 0);
    checkOutput("first_vpos", int'(d_vpos), 0);
    checkOutput("first_visible", int'(d_visible), 1);
    checkOutput("first_line_start", int'(d_ls), 1);
    checkOutput("first_frame_start", int'(d_fs), 1);
    checkOutput("first_hsync", int'(d_hsync), 1);

    vis_count = int'(d_visible);
    hs_low = 0;
    hs_first = -1;
    hs_last = -1;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("second_hpos", int'(d_hpos), 1);
        checkOutput("second_line_start", int'(d_ls), 0);
        checkOutput("second_frame_start", int'(d_fs), 0);
      end
      if (k == 639) checkOutput("visible_at_639", int'(d_visible), 1);
      if (k == 640) checkOutput("visible_at_640", int'(d_visible), 0);
      if (k < 800) begin
        if (d_visible) vis_count++;
        if (!d_hsync) begin
          if (hs_first < 0) hs_first = int'(d_hpos);
          hs_last = int'(d_hpos);
          hs_low++;
        end
      end else begin
        checkOutput("wrap_hpos", int'(d_hpos), 0);
        checkOutput("wrap_vpos", int'(d_vpos), 1);
        checkOutput("wrap_line_start", int'(d_ls), 1);
        checkOutput("wrap_frame_start", int'(d_fs), 0);
      end
    end
    checkOutput("line_visible_clocks", vis_count, 640);
    checkOutput("line_hsync_clocks", hs_low, 96);
    checkOutput("hsync_first_hpos", hs_first, 656);
    checkOutput("hsync_last_hpos", hs_last, 751);

    last_fs = -1;
    fs_gap = -1;
    sv_low = 0;
    iv_high = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (s_fs) begin
        if (last_fs >= 0) fs_gap = edges - last_fs;
        last_fs = edges;
      end
      if (k < 150) begin
        if (!s_vsync) sv_low++;
        if (i_vsync) iv_high++;
      end
    end
    checkOutput("small_frame_period", fs_gap, 150);
    checkOutput("small_vsync_clocks", sv_low, 30);
    checkOutput("inv_vsync_clocks", iv_high, 30);

    for (int n = 0; n < 1000 && (cyc % 800) != 798; n++) tick();
    checkOutput("ce_setup_hpos", int'(d_hpos), 798);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ce1_hpos", int'(d_hpos), 799);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("ce0_hpos", int'(d_hpos), 799);
    checkOutput("ce0_line_start", int'(d_ls), 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ce1b_hpos", int'(d_hpos), 0);
    checkOutput("ce1b_vpos", int'(d_vpos), 2);
    checkOutput("ce1b_line_start", int'(d_ls), 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("ce0b_hpos", int'(d_hpos), 0);
    checkOutput("ce0b_line_start", int'(d_ls), 0);

    ce = 1'b1;
    for (int n = 0; n < 1000 && (cyc % 800) != 300; n++) tick();
    checkOutput("pre_rst_hpos", int'(d_hpos), 300);
    checkOutput("pre_rst_visible", int'(d_visible), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_hpos", int'(d_hpos), 0);
    checkOutput("async_rst_vpos", int'(d_vpos), 0);
    checkOutput("async_rst_visible", int'(d_visible), 0);
    checkOutput("async_rst_hsync", int'(d_hsync), 1);
    checkOutput("async_rst_small_hpos", int'(s_hpos), 0);
    cyc = -1;
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("restart_hpos", int'(d_hpos), 0);
    checkOutput("restart_vpos", int'(d_vpos), 0);
    checkOutput("restart_frame_start", int'(d_fs), 1);
    checkOutput("restart_visible", int'(d_visible), 1);
    checkOutput("restart_small_frame_start", int'(s_fs), 1);
    applyStimulus(1'b0, 1'b1, 200);

    checkOutput("default_model_errors", err_d, 0);
    checkOutput("small_model_errors", err_s, 0);
    checkOutput("inv_model_errors", err_i, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the pixel-generation stages (digit/bitmap renderers).
- Produces the horizontal and vertical pixel position, a visible-area flag, HSYNC/VSYNC, and line/frame start strobes from one pixel-rate clock.
- The position and visible outputs connect directly to the renderers' i_hpos/i_vpos/i_visible inputs. The sync outputs go to the VGA connector pins.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of o_hsync/o_vsync while asserted (0 = active-low)

Ports:
- i_clk  input  1  pixel clock (25 MHz nominal)
- i_rst  input  1  asynchronous, active-high reset
- i_ce  input  1  pixel advance enable; tie to 1 for full-rate operation
- o_hpos  output  10  current horizontal position, 0..H_TOTAL-1
- o_vpos  output  10  current vertical position, 0..V_TOTAL-1
- o_visible  output  1  high when o_hpos<H_VISIBLE and o_vpos<V_VISIBLE
- o_hsync  output  1  horizontal sync, level per SYNC_ACTIVE
- o_vsync  output  1  vertical sync, level per SYNC_ACTIVE
- o_line_start  output  1  one-cycle strobe when o_hpos becomes 0
- o_frame_start  output  1  one-cycle strobe when (o_hpos,o_vpos) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Width rule: both totals must be ≤1024. Counters are 10 bits unsigned; no other wrap is permitted.
- All outputs are registered. Each output describes the position currently held in o_hpos/o_vpos, so all outputs change together on the same clock edge. No combinational path from any input to any output.
- Internal state is two phases, HOLD and RUN.
- While i_rst is high (asynchronous):
  - state = HOLD; o_hpos = 0; o_vpos = 0
  - o_visible = 0; o_hsync = o_vsync = ~SYNC_ACTIVE (inactive)
  - o_line_start = o_frame_start = 0
- HOLD -> RUN on the first rising edge with i_rst low and i_ce high. On that edge the outputs load the values for position (0,0) without advancing:
  - o_visible = 1; o_line_start = 1; o_frame_start = 1
  - syncs inactive
  - Purpose: position (0,0) is never skipped after reset.
- RUN, edge with i_ce high:
  - Horizontal: if o_hpos == H_TOTAL-1, o_hpos <= 0; otherwise o_hpos <= o_hpos+1.
  - Vertical, on horizontal wrap only: if o_vpos == V_TOTAL-1, o_vpos <= 0; otherwise o_vpos <= o_vpos+1.
  - Simultaneous wrap (799,524) -> (0,0) in a single edge.
  - Flags are computed from the next position:
    - o_hsync asserted (= SYNC_ACTIVE) when H_VISIBLE+H_FRONT ≤ next_h < H_VISIBLE+H_FRONT+H_SYNC (656..751)
    - o_vsync asserted when V_VISIBLE+V_FRONT ≤ next_v < V_VISIBLE+V_FRONT+V_SYNC (490..491); it is line-granular, changing only at the edge where hpos wraps to 0
    - o_visible = (next_h < H_VISIBLE) && (next_v < V_VISIBLE)
    - o_line_start = (next_h == 0)
    - o_frame_start = (next_h == 0) && (next_v == 0)
- Edge with i_ce low (either state):
  - counters, o_visible, o_hsync and o_vsync hold
  - o_line_start and o_frame_start are forced to 0, so a strobe lasts exactly one enabled cycle
- Reset mid-frame: outputs go immediately (asynchronously) to their reset values. After release, the HOLD -> RUN sequence restarts the frame at (0,0).
- Frame period with i_ce = 1: 800×525 = 420000 clocks between o_frame_start pulses. Line period: 800 clocks.

Test Plan:
- Reset held 5 cycles, then released with i_ce=1 -> during reset: hpos=0, vpos=0, visible=0, hsync=vsync=1, strobes=0. First edge after release: (0,0), visible=1, line_start=1, frame_start=1. Second edge: hpos=1, both strobes=0.
- Run one line -> visible=1 for hpos 0..639 and 0 at 640. hsync=0 exactly for hpos 656..751 (96 clocks). At hpos 799 the next edge gives hpos=0, vpos=1, line_start=1, frame_start=0.
- Run a full frame -> vsync=0 for all of lines 490 and 491 only (1600 clocks). visible=0 for vpos 480..524. (799,524) -> (0,0) with frame_start=1. frame_start pulses are 420000 clocks apart.
- i_ce toggled 1,0,1,0 from hpos=798 -> hpos sequence 799, 799, 0, 0. line_start is high only on the first cycle at hpos=0 and low on the held cycle.
- Assert i_rst asynchronously mid-clock at (300,200) -> outputs go to reset values before the next edge. After release the frame restarts at (0,0) with frame_start=1.
- Instantiate with SYNC_ACTIVE=1 -> hsync idle 0 and high for hpos 656..751; vsync likewise inverted. Position and visible outputs identical to the default build.
